uart_rx_framer: RTL and testbench

- Sits directly downstream of the UART receive path.
- Consumes the byte stream (data + one-cycle valid) drained from the RX FIFO and parses framed packets: SOF, LEN, LEN payload bytes, checksum.
- Forwards payload bytes with first/last marking, then reports each frame as good or bad.
- Feeds the command decoder; there is no backpressure because the UART cannot be stalled.

---
 rtl/uart_rx_framer.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_framer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// Packet framer behind the UART RX FIFO: SOF, LEN, LEN payload bytes, checksum.
// Define UART_RX_FRAMER_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES idle clocks.
//
// state   | meaning
// IDLE    | hunting for SOF, other bytes dropped silently
// LEN     | next byte is the frame length
// PAYLOAD | forwarding payload bytes, counting down remaining
// CSUM    | next byte closes the frame, sum of LEN..CSUM must be 0 mod 256
module uart_rx_framer #(
  parameter int         D_BITS         = 8,
  parameter logic [7:0] SOF            = 8'hAA,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [D_BITS-1:0] i_data,
  input  logic              i_dvalid,
  output logic [D_BITS-1:0] o_pl_data,
  output logic              o_pl_valid,
  output logic              o_pl_first,
  output logic              o_pl_last,
  output logic              o_frame_ok,
  output logic              o_frame_err,
  output logic [7:0]        o_len,
  output logic [7:0]        o_err_cnt,
  output logic              o_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CSUM    = 2'd3;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [1:0]        state_q, state_d;
  logic [D_BITS-1:0] acc_q, acc_d;
  logic [7:0]        rem_q, rem_d;
  logic [7:0]        len_q, len_d;
  logic [D_BITS-1:0] pl_data_q, pl_data_d;
  logic              pl_valid_q, pl_valid_d;
  logic              pl_first_q, pl_first_d;
  logic              pl_last_q, pl_last_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [D_BITS-1:0] csum_sum;

`ifdef UART_RX_FRAMER_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign csum_sum = acc_q + i_data;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    len_d      = len_q;
    pl_data_d  = pl_data_q;
    pl_valid_d = 1'b0;
    pl_first_d = pl_first_q;
    pl_last_d  = pl_last_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;

    if (i_dvalid) begin
      case (state_q)
        ST_IDLE: begin
          if (i_data == SOF) begin
            state_d    = ST_LEN;
            acc_d      = '0;
            pl_first_d = 1'b0;
            pl_last_d  = 1'b0;
          end
        end
        ST_LEN: begin
          len_d = i_data;
          acc_d = i_data;
          if (i_data == 8'd0) begin
            state_d = ST_CSUM;
          end else if (i_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rem_d   = i_data;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pl_data_d  = i_data;
          pl_valid_d = 1'b1;
          // remaining still equals LEN only before the first payload byte
          pl_first_d = (rem_q == len_q);
          pl_last_d  = (rem_q == 8'd1);
          acc_d      = acc_q + i_data;
          rem_d      = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = ST_CSUM;
        end
        default: begin
          if (csum_sum == '0) ok_d = 1'b1;
          else                err_d = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end

`ifdef UART_RX_FRAMER_TIMEOUT_EN
    tmo_d = tmo_q;
    if (state_q == ST_IDLE || i_dvalid) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d   = '0;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
`endif

    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      pl_data_q  <= '0;
      pl_valid_q <= 1'b0;
      pl_first_q <= 1'b0;
      pl_last_q  <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      pl_data_q  <= pl_data_d;
      pl_valid_q <= pl_valid_d;
      pl_first_q <= pl_first_d;
      pl_last_q  <= pl_last_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

`ifdef UART_RX_FRAMER_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign o_pl_data   = pl_data_q;
  assign o_pl_valid  = pl_valid_q;
  assign o_pl_first  = pl_first_q;
  assign o_pl_last   = pl_last_q;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_len       = len_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: stream-level reference parser, per-cycle compare,
// directed literal vectors and randomized frames.
module tb_uart_rx_framer;

  localparam int         MAX_LEN = 64;
  localparam int         TMO     = 16;
  localparam logic [7:0] SOF     = 8'hAA;
`ifdef UART_RX_FRAMER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_dvalid = 1'b0;
  logic [7:0] o_pl_data;
  logic       o_pl_valid, o_pl_first, o_pl_last;
  logic       o_frame_ok, o_frame_err;
  logic [7:0] o_len, o_err_cnt;
  logic       o_busy;

  uart_rx_framer #(
    .D_BITS(8), .SOF(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .reset(reset), .i_data(i_data), .i_dvalid(i_dvalid),
    .o_pl_data(o_pl_data), .o_pl_valid(o_pl_valid), .o_pl_first(o_pl_first),
    .o_pl_last(o_pl_last), .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err),
    .o_len(o_len), .o_err_cnt(o_err_cnt), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model: bytes of the open frame after SOF, idle count
  bit         m_busy = 1'b0;
  logic [7:0] m_q[$];
  int         m_idle = 0;
  bit         e_valid = 1'b0, e_first = 1'b0, e_last = 1'b0, e_ok = 1'b0, e_err = 1'b0;
  logic [7:0] e_data = 8'h00;
  int         e_len = 0, e_errcnt = 0;

  // observations for literal checks
  logic [9:0] pl_log[$];
  int         ok_seen = 0, err_seen = 0;
  logic [7:0] seq[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_err();
    e_err  = 1'b1;
    m_busy = 1'b0;
    if (e_errcnt < 255) e_errcnt++;
  endtask

  task automatic cyc(input bit dv, input logic [7:0] d);
    int n;
    int L;
    logic [7:0] sum;
    @(negedge i_clk);
    i_dvalid = dv;
    i_data   = d;
    e_valid  = 1'b0;
    e_ok     = 1'b0;
    e_err    = 1'b0;
    if (m_busy) begin
      if (dv) begin
        m_idle = 0;
        m_q.push_back(d);
        n = m_q.size();
        L = int'(m_q[0]);
        if (n == 1) begin
          e_len = L;
          if (L > MAX_LEN) model_err();
        end else if (n - 1 <= L) begin
          e_valid = 1'b1;
          e_data  = d;
          e_first = (n == 2);
          e_last  = (n - 1 == L);
        end else begin
          sum = 8'h00;
          foreach (m_q[i]) sum = sum + m_q[i];
          if (sum == 8'h00) begin
            e_ok   = 1'b1;
            m_busy = 1'b0;
          end else begin
            model_err();
          end
        end
      end else if (TMO_EN) begin
        m_idle++;
        if (m_idle == TMO) model_err();
      end
    end else if (dv && d == SOF) begin
      m_busy = 1'b1;
      m_q.delete();
      m_idle = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic send_q(input logic [7:0] s[$]);
    foreach (s[i]) cyc(1'b1, s[i]);
  endtask

  task automatic do_reset(input int n);
    @(negedge i_clk);
    reset    = 1'b0;
    i_dvalid = 1'b0;
    i_data   = 8'h00;
    m_busy   = 1'b0;
    m_q.delete();
    m_idle   = 0;
    e_valid  = 1'b0;
    e_ok     = 1'b0;
    e_err    = 1'b0;
    e_len    = 0;
    e_errcnt = 0;
    repeat (n) @(negedge i_clk);
    reset = 1'b1;
  endtask

  task automatic clr_logs();
    pl_log.delete();
    ok_seen  = 0;
    err_seen = 0;
  endtask

  task automatic gap_send(input logic [7:0] b);
    int g;
    g = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 3, TMO + 1) : $urandom_range(0, 2);
    idle(g);
    cyc(1'b1, b);
  endtask

  task automatic rand_frame();
    int L, nj, cut;
    logic [7:0] b, sum;
    nj = $urandom_range(0, 2);
    for (int j = 0; j < nj; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SOF) b = 8'h55;
      gap_send(b);
    end
    if ($urandom_range(0, 9) == 0)      L = $urandom_range(MAX_LEN + 1, 255);
    else if ($urandom_range(0, 3) == 0) L = $urandom_range(0, MAX_LEN);
    else                                L = $urandom_range(0, 8);
    cut = ($urandom_range(0, 29) == 0) ? $urandom_range(0, L) : -1;
    gap_send(SOF);
    gap_send(8'(L));
    sum = 8'(L);
    if (L > MAX_LEN) return;
    for (int i = 0; i < L; i++) begin
      if (i == cut) begin
        do_reset(2);
        return;
      end
      b = 8'($urandom_range(0, 255));
      sum = sum + b;
      gap_send(b);
    end
    b = 8'h00 - sum;
    if ($urandom_range(0, 3) == 0) b = b ^ 8'($urandom_range(1, 255));
    gap_send(b);
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      chk("pl_valid", int'(o_pl_valid), int'(e_valid));
      if (e_valid) begin
        chk("pl_data", int'(o_pl_data), int'(e_data));
        chk("pl_first", int'(o_pl_first), int'(e_first));
        chk("pl_last", int'(o_pl_last), int'(e_last));
      end
      chk("frame_ok", int'(o_frame_ok), int'(e_ok));
      chk("frame_err", int'(o_frame_err), int'(e_err));
      chk("len", int'(o_len), e_len);
      chk("err_cnt", int'(o_err_cnt), e_errcnt);
      chk("busy", int'(o_busy), int'(m_busy));
      if (o_pl_valid) pl_log.push_back({o_pl_first, o_pl_last, o_pl_data});
      if (o_frame_ok) ok_seen++;
      if (o_frame_err) err_seen++;
    end
  end

  initial begin
    do_reset(3);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_err_cnt", int'(o_err_cnt), 0);
    chk("rst_len", int'(o_len), 0);
    chk("rst_valid", int'(o_pl_valid), 0);

    // good frame: 03+11+22+33 = 69, checksum 97
    clr_logs();
    seq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_q(seq);
    idle(2);
    chk("good_npl", pl_log.size(), 3);
    if (pl_log.size() == 3) begin
      chk("good_pl0", int'(pl_log[0]), 'h211);
      chk("good_pl1", int'(pl_log[1]), 'h022);
      chk("good_pl2", int'(pl_log[2]), 'h133);
    end
    chk("good_ok", ok_seen, 1);
    chk("good_err", err_seen, 0);
    chk("good_len", int'(o_len), 3);
    chk("good_err_cnt", int'(o_err_cnt), 0);

    clr_logs();
    seq = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h00};
    send_q(seq);
    idle(2);
    chk("badck_npl", pl_log.size(), 2);
    chk("badck_err", err_seen, 1);
    chk("badck_ok", ok_seen, 0);
    chk("badck_err_cnt", int'(o_err_cnt), 1);

    clr_logs();
    seq = '{8'h55, 8'hAA, 8'h00, 8'h00};
    send_q(seq);
    idle(2);
    chk("zero_npl", pl_log.size(), 0);
    chk("zero_ok", ok_seen, 1);
    chk("zero_len", int'(o_len), 0);

    clr_logs();
    seq = '{8'hAA, 8'h41};
    send_q(seq);
    idle(2);
    chk("over_err", err_seen, 1);
    chk("over_busy", int'(o_busy), 0);
    chk("over_len", int'(o_len), 'h41);
    clr_logs();
    seq = '{8'hAA, 8'h01, 8'hAA, 8'h55};
    send_q(seq);
    idle(2);
    chk("recov_npl", pl_log.size(), 1);
    if (pl_log.size() == 1) chk("recov_pl0", int'(pl_log[0]), 'h3AA);
    chk("recov_ok", ok_seen, 1);

    if (TMO_EN) begin
      clr_logs();
      seq = '{8'hAA, 8'h02, 8'h11};
      send_q(seq);
      idle(TMO);
      idle(2);
      chk("tmo_err", err_seen, 1);
      chk("tmo_busy", int'(o_busy), 0);
      clr_logs();
      seq = '{8'hAA, 8'h02, 8'h11};
      send_q(seq);
      idle(TMO - 1);
      seq = '{8'h22, 8'hCB};
      send_q(seq);
      idle(2);
      chk("tmo_edge_err", err_seen, 0);
      chk("tmo_edge_ok", ok_seen, 1);
    end

    clr_logs();
    seq = '{8'hAA, 8'h04, 8'h01};
    send_q(seq);
    do_reset(2);
    seq = '{8'hAA, 8'h01, 8'h07, 8'hF8};
    send_q(seq);
    idle(2);
    chk("rstmid_err", err_seen, 0);
    chk("rstmid_ok", ok_seen, 1);
    chk("rstmid_err_cnt", int'(o_err_cnt), 0);

    clr_logs();
    for (int k = 0; k < 260; k++) begin
      seq = '{8'hAA, 8'h41};
      send_q(seq);
    end
    idle(2);
    chk("sat_err_seen", err_seen, 260);
    chk("sat_err_cnt", int'(o_err_cnt), 255);

    do_reset(2);
    for (int f = 0; f < 300; f++) rand_frame();
    idle(TMO + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
